orion_a2s_bridge: RTL and testbench
===================================

ORION_A2S_BRIDGE -- requirements
Module: orion_a2s_bridge

Interface
REQ-001 SHALL have parameter WIDTH, default 1, meaning bundled-data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning request synchronizer flops; >= 2.
REQ-004 SHALL have parameter ACK_INIT, default 0, meaning reset phase of in_ack; must equal the upstream output-request reset phase (merge PC_INIT).
REQ-005 SHALL use one clock and an asynchronous, active-low reset, named clk and reset_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 in_req  input  1  2-phase request from upstream async stage; asynchronous to clk.
REQ-009 in_ack  output  1  2-phase acknowledge to upstream; registered.
REQ-010 in_data  input  WIDTH  bundled data; stable from in_req toggle until in_ack toggle.
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 out_ready  input  1  downstream accepts head entry.
REQ-013 out_data  output  WIDTH  FIFO head entry.

Function
REQ-014 SHALL pass in_req through SYNC_STAGES flops; req_s is the last stage.
REQ-015 SHALL define token pending as req_s != in_ack.
REQ-016 SHALL write in_data into FIFO at wptr and toggle in_ack in the same clock edge when pending and (count < DEPTH or a pop occurs this cycle).
REQ-017 SHALL hold in_ack unchanged and capture nothing while pending and full without pop; token stays pending until space frees.
REQ-018 SHALL give in_req-toggle-to-in_ack-toggle latency of SYNC_STAGES+1 clk edges (up to one additional edge for asynchronous sampling uncertainty) when not full.
REQ-019 SHALL assert out_valid the cycle after the write into an empty FIFO; out_valid = (count != 0).
REQ-020 SHALL drive out_data combinationally from entry rptr; value meaningless when out_valid is 0.
REQ-021 SHALL pop (rptr+1, count-1) on each edge with out_valid && out_ready.
REQ-022 SHALL on simultaneous write and pop leave count unchanged, advancing both pointers.
REQ-023 SHALL wrap wptr and rptr modulo DEPTH; count is clog2(DEPTH)+1 bits, range 0..DEPTH.
REQ-024 SHALL accept at most one token per clock; pending cannot re-assert before in_ack propagates upstream.
REQ-025 SHALL preserve token order: out_data sequence equals in_data sequence.

Reset
REQ-026 SHALL on reset_n low set in_ack = ACK_INIT, all sync flops = ACK_INIT, wptr = rptr = 0, count = 0, out_valid = 0.
REQ-027 SHALL discard pending and stored tokens on reset mid-operation; upstream is reset concurrently with matching phase.
REQ-028 SHALL leave FIFO storage contents unreset.

Configuration
REQ-029 SHALL, when macro ORION_A2S_BRIDGE_LEVEL_EN is defined, add output port level (clog2(DEPTH)+1 bits) equal to count, reset to 0.
REQ-030 SHALL, when ORION_A2S_BRIDGE_LEVEL_EN is undefined, omit the level port with identical other behaviour.

Verification
REQ-031 Single token: reset, in_data=0x1 (WIDTH=8 bench: 0xA5), toggle in_req 0->1 -> in_ack 0->1 after 3 edges, out_valid=1, out_data=0xA5.
REQ-032 Fill: out_ready=0, send 5 tokens 0x01..0x05, DEPTH=4 -> 4 acks, 5th held pending with in_ack unchanged; raise out_ready -> 5th acked, outputs 0x01..0x05 in order.
REQ-033 Full with pop: FIFO full, token pending, out_ready=1 for one cycle -> pop and write on same edge, count stays 4.
REQ-034 Wrap: stream 10 tokens with out_ready=1 -> 10 outputs in order, pointers wrap, count never exceeds 1.
REQ-035 Reset mid-operation: 2 stored, 1 pending, pulse reset_n low -> out_valid=0, in_ack=ACK_INIT, no stored data emitted.
REQ-036 ACK_INIT=1 with in_req=1 at reset -> no spurious write, out_valid stays 0.

Source files
------------

// File: rtl/orion_a2s_bridge.sv
//============================================================================
// Module   : orion_a2s_bridge
// Brief    : 2-phase bundled-data async handshake to synchronous valid/ready
//            FIFO. Define ORION_A2S_BRIDGE_LEVEL_EN to expose the fill level.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module orion_a2s_bridge #(
  parameter int WIDTH       = 1,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit ACK_INIT    = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_req,
  output logic             in_ack,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef ORION_A2S_BRIDGE_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [SYNC_STAGES-1:0] sync;
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [CW-1:0]          count;
  logic [WIDTH-1:0]       mem [DEPTH];

  logic req_s;
  logic pending;
  logic pop;
  logic push;

  // Synchronizer resets to the ack phase so no token appears pending after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= {SYNC_STAGES{ACK_INIT}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in_req};
    end
  end

  assign req_s     = sync[SYNC_STAGES-1];
  assign pending   = (req_s != in_ack);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees the slot the pending token needs.
  assign push      = pending && ((count < FULL) || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ack <= ACK_INIT;
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wptr   <= wptr + 1'b1;
        in_ack <= ~in_ack;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; out_valid qualifies the head entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_data;
    end
  end

  assign out_data = mem[rptr];

`ifdef ORION_A2S_BRIDGE_LEVEL_EN
  assign level = count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_orion_a2s_bridge.sv
//============================================================================
// Module   : tb_orion_a2s_bridge
// Brief    : Directed self-checking bench for orion_a2s_bridge.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_orion_a2s_bridge;

  logic       clk;
  logic       reset_n;
  logic       in_req;
  logic       in_ack;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  logic       in_req1;
  logic       in_ack1;
  logic [7:0] in_data1;
  logic       out_valid1;
  logic       out_ready1;
  logic [7:0] out_data1;

  int errors = 0;
  int checks = 0;
  int e;

  orion_a2s_bridge #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .ACK_INIT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .in_req(in_req), .in_ack(in_ack),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  orion_a2s_bridge #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .ACK_INIT(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_req(in_req1), .in_ack(in_ack1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Toggle the upstream request and count edges until the ack matches it.
  task automatic send(input logic [7:0] d, input int budget, output int edges);
    in_data = d;
    in_req  = ~in_req;
    edges   = 0;
    while (in_ack !== in_req && edges < budget) begin
      tick();
      edges++;
    end
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_data"}, {24'b0, out_data}, {24'b0, exp});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    in_req     = 1'b0;
    in_data    = 8'h00;
    out_ready  = 1'b0;
    in_req1    = 1'b1;
    in_data1   = 8'h00;
    out_ready1 = 1'b0;
    repeat (3) tick();
    check("rst_ack", {31'b0, in_ack}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst1_ack", {31'b0, in_ack1}, 32'd1);
    reset_n = 1'b1;

    // Single token: exact three-edge latency
    in_data = 8'hA5;
    in_req  = 1'b1;
    tick();
    tick();
    check("lat_edge2_ack", {31'b0, in_ack}, 32'd0);
    check("lat_edge2_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("lat_edge3_ack", {31'b0, in_ack}, 32'd1);
    pop_expect("single", 8'hA5);
    check("single_empty", {31'b0, out_valid}, 32'd0);

    // Fill four entries, fifth token must stall
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), 8, e);
      check("fill_lat", e, 32'd3);
    end
    send(8'h05, 6, e);
    check("held_edges", e, 32'd6);
    check("held_ack", {31'b0, in_ack}, {31'b0, ~in_req});
    check("full_head", {24'b0, out_data}, 32'h01);

    // One pop while full: same-edge write keeps four entries
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("popwr_ack", {31'b0, in_ack}, {31'b0, in_req});
    for (int i = 2; i <= 5; i++) pop_expect("drain", 8'(i));
    check("drain_empty", {31'b0, out_valid}, 32'd0);

    // Streaming with out_ready held: pointers wrap, occupancy stays at one
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(8'h30 + 8'(i), 8, e);
      check("wrap_lat", e, 32'd3);
      check("wrap_data", {24'b0, out_data}, {24'b0, 8'h30 + 8'(i)});
      check("wrap_valid", {31'b0, out_valid}, 32'd1);
      tick();
      check("wrap_popped", {31'b0, out_valid}, 32'd0);
    end
    out_ready = 1'b0;

    // Reset with two stored and one pending
    send(8'h77, 8, e);
    send(8'h78, 8, e);
    check("mid_valid", {31'b0, out_valid}, 32'd1);
    in_data = 8'h79;
    in_req  = ~in_req;
    tick();
    #2;
    reset_n = 1'b0;
    in_req  = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_ack", {31'b0, in_ack}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    check("post_rst_valid", {31'b0, out_valid}, 32'd0);
    check("post_rst_ack", {31'b0, in_ack}, 32'd0);
    out_ready = 1'b0;

    // ACK_INIT=1 instance with in_req high: no spurious write
    check("ack1_idle_ack", {31'b0, in_ack1}, 32'd1);
    check("ack1_idle_valid", {31'b0, out_valid1}, 32'd0);
    in_data1 = 8'h5C;
    in_req1  = 1'b0;
    repeat (3) tick();
    check("ack1_tok_ack", {31'b0, in_ack1}, 32'd0);
    check("ack1_tok_valid", {31'b0, out_valid1}, 32'd1);
    check("ack1_tok_data", {24'b0, out_data1}, 32'h5C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
